// File: rtl/trace_capture_uart_if.sv
// Debug capture bus: sample vector, capture/trigger controls, UART serial line.
// Latency: none (wires only).
// Backpressure: none; the capture side is sampled every cycle.
// master: drives capture_data/capture_enable/trigger, observes uart_tx.
// slave:  the trace capture block; consumes the capture signals, drives uart_tx.
interface trace_capture_uart_if #(
    parameter int CAPTURE_WIDTH_BITS = 32
);
    logic [CAPTURE_WIDTH_BITS-1:0] capture_data;
    logic                          capture_enable;
    logic                          trigger;
    logic                          uart_tx;

    modport master (
        output capture_data,
        output capture_enable,
        output trigger,
        input  uart_tx
    );

    modport slave (
        input  capture_data,
        input  capture_enable,
        input  trigger,
        output uart_tx
    );
endinterface

// File: rtl/trace_capture_uart.sv
// Logic-analyzer: circular capture of a debug vector, dumped oldest-first over 8N1 UART on trigger.
// Latency: first start bit one cycle after entering DUMP; each byte takes 10*BAUD_DIVIDE cycles.
// Backpressure: none; capture is lossless per cycle, the dump runs at a fixed bit rate.
// Ports: clk, reset (async, active-high), bus (slave modport: capture_data,
//        capture_enable, trigger in; uart_tx out, idle high).
module trace_capture_uart #(
    parameter int CAPTURE_WIDTH_BITS = 32,
    parameter int CAPTURE_SIZE       = 64,
    parameter int BAUD_DIVIDE        = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    trace_capture_uart_if.slave   bus
);
    localparam int AW  = $clog2(CAPTURE_SIZE);
    localparam int CW  = AW + 1;
    localparam int NB  = (CAPTURE_WIDTH_BITS + 7) / 8;
    localparam int PW  = NB * 8;
    localparam int BYW = (NB > 1) ? $clog2(NB) : 1;
    localparam int BW  = $clog2(BAUD_DIVIDE);

    localparam logic [CW-1:0]  FULL      = CW'(CAPTURE_SIZE);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIVIDE - 1);
    localparam logic [BYW-1:0] NB_LAST   = BYW'(NB - 1);

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_DUMP,
        ST_STOPPED
    } state_t;

    state_t state, state_nxt;

    logic [CAPTURE_WIDTH_BITS-1:0] mem [CAPTURE_SIZE];
    logic [CAPTURE_WIDTH_BITS-1:0] mem_rd_q;

    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rd_ptr;
    // Number of valid entries while capturing; entries still to send while dumping.
    logic [CW-1:0]  count;
    logic           launched;
    logic [BW-1:0]  baud_cnt;
    logic [3:0]     bit_idx;     // 0 = start, 1..8 = data, 9 = stop
    logic [BYW-1:0] byte_idx;
    logic           uart_tx_q;

    logic           cap_en;
    logic [AW-1:0]  wptr_inc;
    logic [AW-1:0]  wptr_after;
    logic [CW-1:0]  count_after;
    logic [AW-1:0]  start_idx;
    logic           baud_end;
    logic           frame_end;
    logic           entry_end;
    logic           dump_done;
    logic [PW-1:0]  padded;
    logic [7:0]     tx_byte;

    assign cap_en      = (state == ST_CAPTURE) && bus.capture_enable;
    assign wptr_inc    = wptr + 1'b1;
    assign wptr_after  = cap_en ? wptr_inc : wptr;
    assign count_after = (cap_en && (count != FULL)) ? count + 1'b1 : count;
    // Once full, the write pointer points at the oldest surviving sample.
    assign start_idx   = (count_after == FULL) ? wptr_after : '0;

    assign baud_end  = launched && (baud_cnt == BAUD_LAST);
    assign frame_end = baud_end && (bit_idx == 4'd9);
    assign entry_end = frame_end && (byte_idx == NB_LAST);
    assign dump_done = entry_end && (count == CW'(1));

    assign padded = PW'(mem_rd_q);

    always_comb begin
        tx_byte = '0;
        for (int b = 0; b < NB; b++) begin
            if (byte_idx == BYW'(b)) begin
                tx_byte = padded[b*8 +: 8];
            end
        end
    end

    // Buffer: synchronous write, synchronous read of the entry being sent.
    // rd_ptr moves at a frame boundary and the first data bit is BAUD_DIVIDE
    // (>= 2) cycles later, so the 1-cycle read latency is always hidden.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            mem[wptr] <= bus.capture_data;
        end
        mem_rd_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CAPTURE: begin
                if (bus.trigger) begin
                    state_nxt = (count_after == '0) ? ST_STOPPED : ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (dump_done) begin
                    state_nxt = ST_STOPPED;
                end
            end
            ST_STOPPED: state_nxt = ST_STOPPED;
            default:    state_nxt = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            launched  <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    if (cap_en) begin
                        wptr <= wptr_inc;
                    end
                    count <= count_after;
                    if (bus.trigger) begin
                        rd_ptr   <= start_idx;
                        launched <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                ST_DUMP: begin
                    if (!launched) begin
                        // First cycle in DUMP: open the first start bit.
                        launched  <= 1'b1;
                        uart_tx_q <= 1'b0;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                    end else if (!baud_end) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (frame_end) begin
                            if (entry_end) begin
                                count    <= count - 1'b1;
                                rd_ptr   <= rd_ptr + 1'b1;
                                byte_idx <= '0;
                            end else begin
                                byte_idx <= byte_idx + BYW'(1);
                            end
                            bit_idx <= '0;
                            if (dump_done) begin
                                launched  <= 1'b0;
                                uart_tx_q <= 1'b1;
                            end else begin
                                uart_tx_q <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 4'd1;
                            uart_tx_q <= (bit_idx == 4'd8) ? 1'b1 : tx_byte[bit_idx[2:0]];
                        end
                    end
                end
                default: begin
                    uart_tx_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.uart_tx = uart_tx_q;
endmodule

// File: tb/tb_trace_capture_uart.sv
module tb_trace_capture_uart;
    localparam int W  = 12;
    localparam int S  = 4;
    localparam int B  = 4;
    localparam int FL = 10 * B;

    typedef logic [7:0] byte_q_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    trace_capture_uart_if #(.CAPTURE_WIDTH_BITS(W)) bus ();

    trace_capture_uart #(
        .CAPTURE_WIDTH_BITS(W),
        .CAPTURE_SIZE(S),
        .BAUD_DIVIDE(B)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] model_q[$];

    // Reference: the buffer holds the most recent S enabled samples.
    function automatic void model_push(input logic [W-1:0] d);
        model_q.push_back(d);
        if (model_q.size() > S) void'(model_q.pop_front());
    endfunction

    task automatic build_expected(output byte_q_t q);
        logic [15:0] p;
        q = {};
        foreach (model_q[i]) begin
            p = 16'(model_q[i]);
            q.push_back(p[7:0]);
            q.push_back(p[15:8]);
        end
    endtask

    // Called at a negedge; inputs are consumed by the next posedge.
    task automatic step(input logic en, input logic [W-1:0] d, input logic trg);
        bus.capture_enable = en;
        bus.capture_data   = d;
        bus.trigger        = trg;
        @(negedge clk);
        bus.capture_enable = 1'b0;
        bus.trigger        = 1'b0;
    endtask

    task automatic capture(input logic [W-1:0] d);
        model_push(d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
    endtask

    task automatic check_idle(input int n, input string name);
        int ones;
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.uart_tx === 1'b1) ones++;
        end
        total++;
        if (ones !== n) begin
            bad++;
            $display("FAIL idle_%s: high samples=%0d required=%0d", name, ones, n);
        end
    endtask

    task automatic trigger_and_check(input logic en, input logic [W-1:0] d,
                                     input byte_q_t exp, input string name);
        logic [FL-1:0] got, want;
        logic [7:0]    b;
        int            bt;
        step(en, d, 1'b1);
        total++;
        if (bus.uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL prestart_%s: uart_tx=%b required=1", name, bus.uart_tx);
        end
        foreach (exp[k]) begin
            b = exp[k];
            for (int i = 0; i < FL; i++) begin
                @(negedge clk);
                got[i] = bus.uart_tx;
                bt = i / B;
                want[i] = (bt == 0) ? 1'b0 : (bt == 9) ? 1'b1 : b[bt-1];
            end
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL frame_%s[%0d]: got=%h required=%h (byte %h)", name, k, got, want, b);
            end
        end
        check_idle(3 * FL, {name, "_after"});
    endtask

    task automatic test_reset();
        bus.capture_enable = 1'b0;
        bus.capture_data   = '0;
        bus.trigger        = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx: uart_tx=%b required=1", bus.uart_tx);
        end
        @(negedge clk);
        reset = 1'b0;
        check_idle(100, "reset");
    endtask

    task automatic test_two_samples();
        byte_q_t e;
        do_reset();
        capture(12'h123);
        capture(12'hABC);
        e = '{8'h23, 8'h01, 8'hBC, 8'h0A};
        trigger_and_check(1'b0, '0, e, "two");
        check_idle(100, "two_forever");
    endtask

    task automatic test_wrap();
        byte_q_t e;
        do_reset();
        for (int i = 1; i <= 6; i++) capture(W'(i));
        e = '{8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00};
        trigger_and_check(1'b0, '0, e, "wrap");
    endtask

    task automatic test_same_cycle_trigger();
        byte_q_t e;
        do_reset();
        capture(12'h100);
        e = '{8'h00, 8'h01, 8'hFF, 8'h07};
        trigger_and_check(1'b1, 12'h7FF, e, "same");
        step(1'b1, 12'h321, 1'b0);
        step(1'b1, 12'h654, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 12'h777, 1'b1);
        check_idle(100, "same_stopped");
    endtask

    task automatic test_empty_trigger();
        byte_q_t e;
        do_reset();
        e = {};
        trigger_and_check(1'b0, '0, e, "empty");
        check_idle(100, "empty_long");
    endtask

    task automatic test_reset_mid_dump();
        byte_q_t e;
        do_reset();
        capture(12'h3C5);
        capture(12'h2A6);
        step(1'b0, '0, 1'b1);
        repeat (FL + 1) @(negedge clk);
        total++;
        if (bus.uart_tx !== 1'b0) begin
            bad++;
            $display("FAIL middump_startbit: uart_tx=%b required=0", bus.uart_tx);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (bus.uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL middump_reset_tx: uart_tx=%b required=1", bus.uart_tx);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        capture(12'h055);
        e = '{8'h55, 8'h00};
        trigger_and_check(1'b0, '0, e, "after_reset");
    endtask

    task automatic test_random();
        byte_q_t      e;
        int           n;
        logic         en;
        logic [W-1:0] d;
        for (int r = 0; r < 10; r++) begin
            do_reset();
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) begin
                en = ($urandom_range(0, 3) != 0);
                d  = W'($urandom);
                if (en) model_push(d);
                step(en, d, 1'b0);
            end
            en = ($urandom_range(0, 1) != 0);
            d  = W'($urandom);
            if (en) model_push(d);
            build_expected(e);
            trigger_and_check(en, d, e, $sformatf("rand%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_two_samples();
        test_wrap();
        test_same_cycle_trigger();
        test_empty_trigger();
        test_reset_mid_dump();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trace_capture_uart.md
Name: trace_capture_uart

Overview:
- Debug logic-analyzer block.
- Records a sample of an arbitrary-width debug vector into a circular on-chip buffer on every cycle that capture is enabled.
- When a trigger fires, it freezes the buffer and streams its contents, oldest sample first, out a serial UART transmit pin.
- Sits beside the processor in the top-level system and observes internal debug signals, e.g. synchronized load/store events.

Parameters:
- CAPTURE_WIDTH_BITS, 32: width of one captured sample in bits (any value ≥1).
- CAPTURE_SIZE, 64: number of sample entries in the buffer; power of two, ≥2.
- BAUD_DIVIDE, 434: clock cycles per UART bit (≥2), e.g. 50000000/115200.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- capture_data  input  CAPTURE_WIDTH_BITS  sample to record.
- capture_enable  input  1  record capture_data this cycle.
- trigger  input  1  stop capturing and start the dump (level, sampled each cycle).
- uart_tx  output  1  UART serial out, 8N1, idle high.

Behaviour:
- Reset is asynchronous and active-high on clk; clock is clk.
- Reset values:
  - state = CAPTURE
  - write pointer = 0
  - entry count = 0
  - uart_tx = 1
  - bit-timing counters = 0
- States and transitions:
  - CAPTURE → DUMP when trigger=1.
  - DUMP → STOPPED after the last byte's stop bit completes.
  - STOPPED is terminal until reset.
- CAPTURE:
  - When capture_enable=1, write capture_data to buffer[wptr].
  - wptr increments modulo CAPTURE_SIZE (wraps, overwriting the oldest entry).
  - count saturates at CAPTURE_SIZE.
- Trigger in CAPTURE:
  - A sample enabled in the same cycle as trigger is recorded, then capture freezes.
  - Next state is DUMP.
  - Dump start index = (count==CAPTURE_SIZE) ? wptr : 0.
  - Entries to send = count, including that final sample.
- Trigger and capture_enable are ignored in DUMP and STOPPED.
- If count==0 at trigger, go directly to STOPPED; no bytes are sent.
- Dump format:
  - Each entry is sent as NB = ceil(CAPTURE_WIDTH_BITS/8) bytes, least-significant byte first.
  - Unused high bits of the final byte are sent as 0.
  - Entries go in order start, start+1, … modulo CAPTURE_SIZE.
  - There is no framing or header; bytes are sent back-to-back with no idle gap beyond the stop bit.
- UART transmitter:
  - Frame = start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held for exactly BAUD_DIVIDE cycles, so one byte takes 10×BAUD_DIVIDE cycles.
  - The first start bit begins on the cycle after the state enters DUMP (latency 1).
  - The next byte's start bit immediately follows the previous stop bit.
  - uart_tx is registered (glitch-free).
- Buffer storage:
  - May be inferred synchronous RAM (1-cycle read latency).
  - The implementation must prefetch so timing above holds.
- Reset mid-dump aborts transmission immediately: uart_tx=1, state returns to CAPTURE, buffer contents are treated as empty (count=0).

Test Plan:
Directed scenarios use CAPTURE_WIDTH_BITS=12, CAPTURE_SIZE=4, BAUD_DIVIDE=4.
- Idle after reset, no trigger for 100 cycles → uart_tx constantly 1.
- Capture 0x123 and 0xABC (2 enabled cycles), then trigger → 4 bytes on the wire: 0x23, 0x01, 0xBC, 0x0A.
  - Each frame is 40 cycles; total 160 cycles; then uart_tx stays 1 forever.
- Capture 6 samples 0x001..0x006 (wraps), trigger → bytes 03 00 04 00 05 00 06 00 (oldest four, oldest first).
- Trigger asserted in the same cycle as capture of 0x7FF, after 0x100 → bytes 00 01 FF 07.
  - Later captures and triggers produce no further output.
- Trigger with no captures → no start bit ever appears; uart_tx stays 1.
- Assert reset during the second byte of a dump → uart_tx=1 immediately.
  - Then capture 0x055 and trigger → single entry 55 00 sent.
